// File: rtl/mac_block_seq.sv
// Block sequencer for one sparse MAC lane: loads compressed blocks, starts the lane,
// serves its operand lookups and chains the partial sum across blocks of a job.
module mac_block_seq #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BLOCK_DEPTH = 32,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ACC_W       = DATA_WIDTH * 2 + $clog2(BLOCK_DEPTH * 3),
  localparam int unsigned OFF_W      = $clog2(BLOCK_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              job_val,
  output logic                              job_rdy,
  input  logic [CNT_W-1:0]                  job_nblk,
  input  logic [ACC_W-1:0]                  job_psum,
  input  logic                              blk_val,
  output logic                              blk_rdy,
  input  logic [BLOCK_DEPTH-1:0]            blk_flg_act,
  input  logic [BLOCK_DEPTH-1:0]            blk_flg_wei,
  input  logic [BLOCK_DEPTH*DATA_WIDTH-1:0] blk_act,
  input  logic [BLOCK_DEPTH*DATA_WIDTH-1:0] blk_wei,
  output logic                              PECMAC_Sta,
  input  logic                              MACPEC_Fnh,
  output logic [BLOCK_DEPTH-1:0]            PECMAC_FlgAct,
  output logic [BLOCK_DEPTH-1:0]            PECMAC_FlgWei,
  input  logic                              MACAW_ValOffset,
  input  logic [OFF_W-1:0]                  MACAW_OffsetAct,
  input  logic [OFF_W-1:0]                  MACAW_OffsetWei,
  output logic [DATA_WIDTH-1:0]             PECMAC_Act,
  output logic [DATA_WIDTH-1:0]             PECMAC_Wei,
  output logic                              PECMAC_ActWei_Val,
  output logic [ACC_W-1:0]                  MACMAC_Mac,
  input  logic [ACC_W-1:0]                  MACCNV_Mac,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [ACC_W-1:0]                  out_psum,
  output logic                              busy
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StRun, StDrain, StNext, StOut
  } state_e;

  state_e                                       state_q, state_d;
  logic [ACC_W-1:0]                             psum_q, psum_d;
  logic [CNT_W-1:0]                             blk_left_q, blk_left_d;
  logic [BLOCK_DEPTH-1:0]                       flg_act_q, flg_act_d;
  logic [BLOCK_DEPTH-1:0]                       flg_wei_q, flg_wei_d;
  logic [BLOCK_DEPTH-1:0][DATA_WIDTH-1:0]       act_q, act_d;
  logic [BLOCK_DEPTH-1:0][DATA_WIDTH-1:0]       wei_q, wei_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      psum_q     <= '0;
      blk_left_q <= '0;
      flg_act_q  <= '0;
      flg_wei_q  <= '0;
      act_q      <= '0;
      wei_q      <= '0;
    end else begin
      state_q    <= state_d;
      psum_q     <= psum_d;
      blk_left_q <= blk_left_d;
      flg_act_q  <= flg_act_d;
      flg_wei_q  <= flg_wei_d;
      act_q      <= act_d;
      wei_q      <= wei_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    psum_d            = psum_q;
    blk_left_d        = blk_left_q;
    flg_act_d         = flg_act_q;
    flg_wei_d         = flg_wei_q;
    act_d             = act_q;
    wei_d             = wei_q;
    job_rdy           = 1'b0;
    blk_rdy           = 1'b0;
    PECMAC_Sta        = 1'b0;
    PECMAC_ActWei_Val = 1'b0;
    PECMAC_Act        = '0;
    PECMAC_Wei        = '0;
    MACMAC_Mac        = '0;
    out_val           = 1'b0;
    out_psum          = '0;

    unique case (state_q)
      StIdle: begin
        job_rdy = 1'b1;
        if (job_val) begin
          psum_d     = job_psum;
          // A zero block count still runs one block.
          blk_left_d = (job_nblk == '0) ? CNT_W'(1) : job_nblk;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        blk_rdy = blk_val;
        if (blk_val) begin
          flg_act_d = blk_flg_act;
          flg_wei_d = blk_flg_wei;
          act_d     = blk_act;
          wei_d     = blk_wei;
          state_d   = StStart;
        end
      end
      StStart: begin
        PECMAC_Sta = 1'b1;
        MACMAC_Mac = psum_q;
        state_d    = StRun;
      end
      StRun: begin
        PECMAC_ActWei_Val = 1'b1;
        PECMAC_Act        = act_q[MACAW_OffsetAct];
        PECMAC_Wei        = wei_q[MACAW_OffsetWei];
        if (MACPEC_Fnh && !MACAW_ValOffset) state_d = StDrain;
      end
      StDrain: begin
        // Lane's final accumulate has landed by now; take it as the chained sum.
        psum_d     = MACCNV_Mac;
        blk_left_d = blk_left_q - CNT_W'(1);
        state_d    = StNext;
      end
      StNext: begin
        state_d = (blk_left_q == '0) ? StOut : StLoad;
      end
      StOut: begin
        out_val  = 1'b1;
        out_psum = psum_q;
        if (out_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign PECMAC_FlgAct = flg_act_q;
  assign PECMAC_FlgWei = flg_wei_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_mac_block_seq.sv
// Bench for mac_block_seq: behavioural sparse MAC lane plus a scoreboard of the expected
// per-block start sums and final job sums.
module tb_mac_block_seq;
  localparam int DW = 8;
  localparam int BD = 32;
  localparam int CW = 8;
  localparam int AW = DW * 2 + $clog2(BD * 3);
  localparam int OW = $clog2(BD);
  localparam int MaxBlk = 4;

  logic                  clk, rst_n;
  logic                  job_val, job_rdy;
  logic [CW-1:0]         job_nblk;
  logic signed [AW-1:0]  job_psum;
  logic                  blk_val, blk_rdy;
  logic [BD-1:0]         blk_flg_act, blk_flg_wei;
  logic [BD*DW-1:0]      blk_act, blk_wei;
  logic                  PECMAC_Sta, MACPEC_Fnh;
  logic [BD-1:0]         PECMAC_FlgAct, PECMAC_FlgWei;
  logic                  MACAW_ValOffset;
  logic [OW-1:0]         MACAW_OffsetAct, MACAW_OffsetWei;
  logic [DW-1:0]         PECMAC_Act, PECMAC_Wei;
  logic                  PECMAC_ActWei_Val;
  logic signed [AW-1:0]  MACMAC_Mac, MACCNV_Mac;
  logic                  out_val, out_rdy;
  logic signed [AW-1:0]  out_psum;
  logic                  busy;

  mac_block_seq dut (
    .clk(clk), .rst_n(rst_n),
    .job_val(job_val), .job_rdy(job_rdy), .job_nblk(job_nblk), .job_psum(job_psum),
    .blk_val(blk_val), .blk_rdy(blk_rdy), .blk_flg_act(blk_flg_act), .blk_flg_wei(blk_flg_wei),
    .blk_act(blk_act), .blk_wei(blk_wei),
    .PECMAC_Sta(PECMAC_Sta), .MACPEC_Fnh(MACPEC_Fnh),
    .PECMAC_FlgAct(PECMAC_FlgAct), .PECMAC_FlgWei(PECMAC_FlgWei),
    .MACAW_ValOffset(MACAW_ValOffset), .MACAW_OffsetAct(MACAW_OffsetAct),
    .MACAW_OffsetWei(MACAW_OffsetWei), .PECMAC_Act(PECMAC_Act), .PECMAC_Wei(PECMAC_Wei),
    .PECMAC_ActWei_Val(PECMAC_ActWei_Val), .MACMAC_Mac(MACMAC_Mac), .MACCNV_Mac(MACCNV_Mac),
    .out_val(out_val), .out_rdy(out_rdy), .out_psum(out_psum), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_lat = 2;
  int job_cyc = 0;
  bit sta_pending = 1'b0;
  int sta_cnt = 0;
  int blk_cnt = 0;
  int pair_cnt = 0;
  logic signed [AW-1:0] mac_exp_q[$];
  logic signed [AW-1:0] out_exp_q[$];

  logic [BD-1:0]    bfa[MaxBlk];
  logic [BD-1:0]    bfw[MaxBlk];
  logic [BD*DW-1:0] ba[MaxBlk];
  logic [BD*DW-1:0] bw[MaxBlk];

  task automatic check_eq(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural lane ----------------
  function automatic int nth_set(input logic [BD-1:0] m, input int k);
    int c = 0;
    for (int i = 0; i < BD; i++) begin
      if (m[i]) begin
        if (c == k) return i;
        c++;
      end
    end
    return 0;
  endfunction

  function automatic logic [OW-1:0] rank_of(input logic [BD-1:0] f, input int pos);
    int r = 0;
    for (int i = 0; i < pos; i++) r += int'(f[i]);
    return OW'(r);
  endfunction

  logic [BD-1:0]        lane_fa, lane_fw;
  logic                 lane_val, lane_fnh;
  logic signed [AW-1:0] lane_acc;
  int                   lane_k, lane_n;

  assign MACAW_ValOffset = lane_val;
  assign MACPEC_Fnh      = lane_fnh;
  assign MACCNV_Mac      = lane_acc;
  assign MACAW_OffsetAct = lane_val ? rank_of(lane_fa, nth_set(lane_fa & lane_fw, lane_k)) : '0;
  assign MACAW_OffsetWei = lane_val ? rank_of(lane_fw, nth_set(lane_fa & lane_fw, lane_k)) : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_fa <= '0; lane_fw <= '0; lane_val <= 1'b0; lane_fnh <= 1'b0;
      lane_acc <= '0; lane_k <= 0; lane_n <= 0;
    end else if (PECMAC_Sta) begin
      lane_fa  <= PECMAC_FlgAct;
      lane_fw  <= PECMAC_FlgWei;
      lane_acc <= MACMAC_Mac;
      lane_k   <= 0;
      lane_n   <= $countones(PECMAC_FlgAct & PECMAC_FlgWei);
      lane_val <= |(PECMAC_FlgAct & PECMAC_FlgWei);
      lane_fnh <= ~|(PECMAC_FlgAct & PECMAC_FlgWei);
    end else if (lane_val && PECMAC_ActWei_Val) begin
      lane_acc <= lane_acc + $signed(PECMAC_Act) * $signed(PECMAC_Wei);
      lane_k   <= lane_k + 1;
      if (lane_k + 1 == lane_n) begin
        lane_val <= 1'b0;
        lane_fnh <= 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic signed [AW-1:0] model_block(input int b);
    logic signed [AW-1:0] s = '0;
    logic signed [DW-1:0] av, wv;
    int ra = 0;
    int rw = 0;
    for (int i = 0; i < BD; i++) begin
      if (bfa[b][i] && bfw[b][i]) begin
        av = ba[b][ra*DW +: DW];
        wv = bw[b][rw*DW +: DW];
        s  = s + av * wv;
      end
      ra += int'(bfa[b][i]);
      rw += int'(bfw[b][i]);
    end
    return s;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (job_val && job_rdy) begin
        job_cyc     = cyc;
        sta_pending = 1'b1;
      end
      if (blk_rdy) blk_cnt++;
      if (PECMAC_ActWei_Val && MACAW_ValOffset) pair_cnt++;
      if (PECMAC_Sta) begin
        sta_cnt++;
        if (mac_exp_q.size() == 0) check_eq("sta_unexpected", 1, 0);
        else check_eq("sta_mac", MACMAC_Mac, mac_exp_q.pop_front());
        if (sta_pending) check_eq("sta_latency", cyc - job_cyc, exp_lat);
        sta_pending = 1'b0;
      end
      if (out_val && out_rdy) begin
        if (out_exp_q.size() == 0) check_eq("out_unexpected", 1, 0);
        else check_eq("out_psum", out_psum, out_exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_job_rdy"}, job_rdy, 1);
    check_eq({tag, "_blk_rdy"}, blk_rdy, 0);
    check_eq({tag, "_sta"}, PECMAC_Sta, 0);
    check_eq({tag, "_actwei_val"}, PECMAC_ActWei_Val, 0);
    check_eq({tag, "_out_val"}, out_val, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_out_psum"}, out_psum, 0);
    check_eq({tag, "_mac"}, MACMAC_Mac, 0);
    check_eq({tag, "_flags"}, {PECMAC_FlgAct, PECMAC_FlgWei}, 0);
    check_eq({tag, "_operands"}, {PECMAC_Act, PECMAC_Wei}, 0);
  endtask

  task automatic set_dense(input int b, input logic [BD-1:0] fa, input logic [BD-1:0] fw,
                           input logic [DW-1:0] av, input logic [DW-1:0] wv);
    bfa[b] = fa;
    bfw[b] = fw;
    for (int i = 0; i < BD; i++) begin
      ba[b][i*DW +: DW] = av;
      bw[b][i*DW +: DW] = wv;
    end
  endtask

  task automatic set_rand(input int b);
    bfa[b] = $urandom & $urandom;
    bfw[b] = $urandom | ($urandom & $urandom);
    for (int i = 0; i < BD; i++) begin
      ba[b][i*DW +: DW] = DW'($urandom);
      bw[b][i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic run_job(input int nblk, input logic signed [AW-1:0] psum, input int blk_hold,
                         input int out_hold, input int abort_blk);
    int nb = (nblk == 0) ? 1 : nblk;
    logic signed [AW-1:0] acc = psum;
    int exp_pairs = 0;
    int sta0 = sta_cnt;
    int blk0 = blk_cnt;
    int pair0 = pair_cnt;
    int t;
    for (int b = 0; b < nb; b++) begin
      mac_exp_q.push_back(acc);
      acc = acc + model_block(b);
      exp_pairs += $countones(bfa[b] & bfw[b]);
    end
    if (abort_blk == 0) out_exp_q.push_back(acc);
    exp_lat = 2 + blk_hold;

    @(negedge clk);
    job_val  = 1'b1;
    job_nblk = CW'(nblk);
    job_psum = psum;
    @(negedge clk);
    job_val = 1'b0;

    for (int b = 0; b < nb; b++) begin
      blk_flg_act = bfa[b];
      blk_flg_wei = bfw[b];
      blk_act     = ba[b];
      blk_wei     = bw[b];
      if (b == 0 && blk_hold > 0) begin
        blk_val = 1'b0;
        repeat (blk_hold) @(negedge clk);
      end
      blk_val = 1'b1;
      t = 0;
      #1;
      while (!blk_rdy && t < 500) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t >= 500) check_eq("blk_rdy_timeout", 0, 1);
      @(negedge clk);
      if (abort_blk == b + 1) begin
        @(negedge clk);
        #1;
        check_eq("abort_in_run", PECMAC_ActWei_Val, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        blk_val = 1'b0;
        mac_exp_q.delete();
        sta_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    blk_val = 1'b0;

    t = 0;
    #1;
    while (!out_val && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 2000) check_eq("out_val_timeout", 0, 1);
    for (int i = 1; i < out_hold; i++) begin
      @(negedge clk);
      #1;
      check_eq("out_hold_val", out_val, 1);
      check_eq("out_hold_psum", out_psum, acc);
    end
    @(negedge clk);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    check_eq("out_drop", out_val, 0);
    check_eq("sta_count", sta_cnt - sta0, nb);
    check_eq("blk_pulses", blk_cnt - blk0, nb);
    check_eq("lane_pairs", pair_cnt - pair0, exp_pairs);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; job_val = 1'b0; job_nblk = '0; job_psum = '0;
    blk_val = 1'b0; blk_flg_act = '0; blk_flg_wei = '0; blk_act = '0; blk_wei = '0;
    out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single dense block: 32 * (1*2).
    set_dense(0, '1, '1, 8'd1, 8'd2);
    run_job(1, 0, 0, 1, 0);

    // Chaining: one match per block at differing packed positions.
    set_dense(0, 32'h1, 32'h1, 8'd0, 8'd0);
    ba[0][0*DW +: DW] = 8'd3;
    bw[0][0*DW +: DW] = 8'd4;
    set_dense(1, 32'h9, 32'h28, 8'd99, 8'd77);
    ba[1][1*DW +: DW] = 8'd5;
    bw[1][0*DW +: DW] = -8'sd2;
    set_dense(2, 32'h80, 32'h86, 8'd11, 8'd50);
    ba[2][0*DW +: DW] = 8'd7;
    bw[2][2*DW +: DW] = 8'd1;
    run_job(3, -10, 0, 1, 0);

    // Empty block with a zero block count.
    set_dense(0, 32'hFFFF_0000, 32'h0000_FFFF, 8'd5, 8'd6);
    run_job(0, 1234, 0, 1, 0);

    // Backpressure on both block input and result output.
    set_rand(0);
    run_job(1, -77, 5, 4, 0);

    // Signed extremes: 32 * (-128 * -128).
    set_dense(0, '1, '1, 8'h80, 8'h80);
    run_job(1, 0, 0, 1, 0);

    // Reset during block 2 of 3, then a fresh job.
    set_dense(0, '1, '1, 8'd1, 8'd1);
    set_dense(1, '1, '1, 8'd2, 8'd3);
    set_dense(2, '1, '1, 8'd4, 8'd5);
    run_job(3, 100, 0, 1, 2);
    set_rand(0);
    set_rand(1);
    run_job(2, 42, 0, 2, 0);

    for (int j = 0; j < 4; j++) begin
      int nb = int'($urandom_range(1, MaxBlk));
      int p  = int'($urandom_range(2000)) - 1000;
      for (int b = 0; b < nb; b++) set_rand(b);
      run_job(nb, AW'(p), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 0);
    end

    check_eq("scoreboard_drained", mac_exp_q.size() + out_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
